// File: rtl/ex_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// ex_muldiv_sequencer
//
// Iterative multiply/divide unit that sits beside the EX stage and owns the
// architectural HI/LO registers. A MULT/MULTU/DIV/DIVU held in EX is accepted
// from IDLE, then run over XLEN iteration cycles on a shared radix-2 datapath
// (shift/add for multiply, restoring shift/subtract for divide). A single FIX
// cycle applies sign correction and commits HI/LO on its exiting edge. MTHI and
// MTLO write HI/LO directly from IDLE without stalling.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   EX holds a valid muldiv/MTHI/MTLO instruction (held while stalled)
//   funct  in   R-type funct field selecting the operation
//   flush  in   squash the in-flight operation (takes priority over everything)
//   op_a   in   forwarded rs: multiplicand / dividend / MT source
//   op_b   in   forwarded rt: multiplier / divisor
//   stall  out  hold PC, IF/ID and ID/EX while the operation is accepted/iterating
//   busy   out  sequencer is not idle
//   done   out  high during the FIX (commit) cycle only
//   hi     out  HI register
//   lo     out  LO register
// ---------------------------------------------------------------------------
module ex_muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [5:0]      funct,
   input  logic            flush,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);

   localparam logic [5:0] F_MTHI = 6'h11;
   localparam logic [5:0] F_MTLO = 6'h13;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   state_t            state;
   logic [CW-1:0]     count;
   // Multiplicand (multiply) or divisor (divide), always a magnitude for signed ops.
   logic [XLEN-1:0]   opnd;
   // Multiply: running product. Divide: {remainder, quotient} pair.
   logic [2*XLEN-1:0] acc;
   logic              is_div;
   logic              neg_q;      // quotient / product must be negated in FIX
   logic              neg_r;      // remainder takes a negative dividend's sign
   logic              div_zero;   // divisor was zero: LO forced to all-ones

   // ---------------------------------------------------------------------
   // Instruction decode and operand preparation
   // ---------------------------------------------------------------------
   logic            is_muldiv;
   logic            op_signed;
   logic            op_is_div;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            accept;

   // 0x18..0x1B share funct[5:2]; funct[1] selects divide, funct[0] unsigned.
   assign is_muldiv = (funct[5:2] == 4'b0110);
   assign op_is_div = funct[1];
   assign op_signed = ~funct[0];
   assign a_neg     = op_signed & op_a[XLEN-1];
   assign b_neg     = op_signed & op_b[XLEN-1];
   assign a_mag     = a_neg ? -op_a : op_a;
   assign b_mag     = b_neg ? -op_b : op_b;

   assign accept = (state == S_IDLE) & start & is_muldiv;

   // stall must cover the acceptance cycle combinationally so the instruction
   // never slips out of EX; it is deliberately low in FIX so the instruction
   // leaves EX on the same edge HI/LO commit.
   assign stall = accept | (state == S_MUL) | (state == S_DIV);
   assign busy  = (state != S_IDLE);
   assign done  = (state == S_FIX);

   // ---------------------------------------------------------------------
   // Multiply step: conditional add into the upper half, then shift right,
   // keeping the carry out of the add as the new product MSB.
   // ---------------------------------------------------------------------
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;

   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   // ---------------------------------------------------------------------
   // Restoring divide step. trial is the shifted-in partial remainder; it can
   // be one bit wider than XLEN before the subtract. When trial >= divisor the
   // true difference is below the divisor, so the XLEN-bit modular difference
   // is exact.
   // ---------------------------------------------------------------------
   logic [XLEN:0]     trial;
   logic              trial_ge;
   logic [XLEN-1:0]   trial_diff;
   logic [XLEN-1:0]   quo_shift;
   logic [2*XLEN-1:0] div_next;

   assign trial      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign trial_ge   = (trial >= {1'b0, opnd});
   assign trial_diff = trial[XLEN-1:0] - opnd;
   assign quo_shift  = {acc[XLEN-2:0], 1'b0};
   assign div_next   = trial_ge ? {trial_diff, quo_shift | XLEN'(1)}
                                : {trial[XLEN-1:0], quo_shift};

   wire last_iter = (count == CW'(XLEN - 1));

   // ---------------------------------------------------------------------
   // FIX-cycle sign correction and result selection
   // ---------------------------------------------------------------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   fix_hi;
   logic [XLEN-1:0]   fix_lo;

   always_comb begin
      // NOTE: every output of a combinational block gets a default up front so
      // no path leaves it unassigned (which would infer a latch).
      prod_fix = acc;
      fix_hi   = acc[2*XLEN-1:XLEN];
      fix_lo   = acc[XLEN-1:0];
      if (is_div) begin
         if (div_zero) begin
            fix_lo = '1;
         end else if (neg_q) begin
            fix_lo = -acc[XLEN-1:0];
         end
         if (neg_r) begin
            fix_hi = -acc[2*XLEN-1:XLEN];
         end
      end else begin
         if (neg_q) begin
            prod_fix = -acc;
         end
         fix_hi = prod_fix[2*XLEN-1:XLEN];
         fix_lo = prod_fix[XLEN-1:0];
      end
   end

   // ---------------------------------------------------------------------
   // Sequencer state, working registers and HI/LO
   // ---------------------------------------------------------------------
   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         count    <= '0;
         opnd     <= '0;
         acc      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else if (flush) begin
         // Squash wins over acceptance, MT writes and the FIX commit.
         state <= S_IDLE;
         count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (is_muldiv) begin
                     opnd     <= op_is_div ? b_mag : a_mag;
                     acc      <= {{XLEN{1'b0}}, (op_is_div ? a_mag : b_mag)};
                     is_div   <= op_is_div;
                     neg_q    <= a_neg ^ b_neg;
                     neg_r    <= a_neg;
                     div_zero <= (op_b == '0);
                     count    <= '0;
                     state    <= op_is_div ? S_DIV : S_MUL;
                  end else if (funct == F_MTHI) begin
                     hi <= op_a;
                  end else if (funct == F_MTLO) begin
                     lo <= op_a;
                  end
               end
            end

            S_MUL: begin
               acc   <= mul_next;
               count <= count + 1'b1;
               if (last_iter) begin
                  state <= S_FIX;
               end
            end

            S_DIV: begin
               acc   <= div_next;
               count <= count + 1'b1;
               if (last_iter) begin
                  state <= S_FIX;
               end
            end

            S_FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for ex_muldiv_sequencer. Inputs are driven 1
// time unit after the rising edge; outputs are sampled 2 units after it.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_sequencer;

   localparam int XLEN = 32;

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [5:0]      funct;
   logic            flush;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ex_muldiv_sequencer #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .funct (funct),
      .flush (flush),
      .op_a  (op_a),
      .op_b  (op_b),
      .stall (stall),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one muldiv instruction, holding start until it leaves EX (the
   // cycle in which stall is low). Returns at edge+1 after the commit edge.
   task automatic do_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int stall_cycles,
                        output int done_cycles);
      bit fin;
      start        = 1'b1;
      funct        = f;
      op_a         = a;
      op_b         = b;
      stall_cycles = 0;
      done_cycles  = 0;
      fin          = 1'b0;
      for (int i = 0; i < 60 && !fin; i++) begin
         #1;
         if (stall) stall_cycles++;
         if (done)  done_cycles++;
         if (!stall) fin = 1'b1;
         tick();
      end
      start = 1'b0;
      funct = 6'h00;
      check("op_completes_within_budget", 32'(fin), 32'd1);
   endtask

   int sc;
   int dc;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      funct = 6'h00;
      flush = 1'b0;
      op_a  = '0;
      op_b  = '0;

      // Asynchronous reset with no clock edge required.
      #1 reset = 1'b0;
      #1;
      check("reset_hi",    hi,    32'h0);
      check("reset_lo",    lo,    32'h0);
      check("reset_busy",  32'(busy),  32'd0);
      check("reset_done",  32'(done),  32'd0);
      check("reset_stall", 32'(stall), 32'd0);
      tick();
      tick();
      reset = 1'b1;

      // MULTU max x max: stall spans acceptance + 32 iterations.
      do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc, dc);
      check("multu_stall_cycles", 32'(sc), 32'd33);
      check("multu_done_cycles",  32'(dc), 32'd1);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);
      check("multu_busy_after", 32'(busy), 32'd0);

      // MULT -3 x 7 = -21.
      do_op(F_MULT, 32'hFFFF_FFFD, 32'd7, sc, dc);
      check("mult_neg_hi", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo", lo, 32'hFFFF_FFEB);
      check("mult_neg_done_cycles", 32'(dc), 32'd1);

      // DIV -7 / 2: quotient truncates toward zero, remainder follows dividend.
      do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, sc, dc);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);
      check("div_stall_cycles", 32'(sc), 32'd33);

      // DIVU 100 / 7.
      do_op(F_DIVU, 32'd100, 32'd7, sc, dc);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      // DIVU 5 / 0.
      do_op(F_DIVU, 32'd5, 32'd0, sc, dc);
      check("divu_zero_lo", lo, 32'hFFFF_FFFF);
      check("divu_zero_hi", hi, 32'd5);

      // Signed divide by zero with a negative dividend.
      do_op(F_DIV, 32'hFFFF_FFF9, 32'd0, sc, dc);
      check("div_zero_lo", lo, 32'hFFFF_FFFF);
      check("div_zero_hi", hi, 32'hFFFF_FFF9);

      // Signed overflow.
      do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, sc, dc);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'h0);

      // MULT with start held to completion, then MTLO as the next instruction.
      do_op(F_MULT, 32'd6, 32'd7, sc, dc);
      check("mult_small_lo", lo, 32'd42);
      check("mult_small_hi", hi, 32'd0);
      start = 1'b1;
      funct = F_MTLO;
      op_a  = 32'h0000_1234;
      #1;
      check("mtlo_no_stall", 32'(stall), 32'd0);
      tick();
      check("mtlo_lo", lo, 32'h0000_1234);
      check("mtlo_hi_kept", hi, 32'd0);
      check("mtlo_busy", 32'(busy), 32'd0);
      start = 1'b0;
      tick();
      check("mtlo_no_restart", 32'(busy), 32'd0);

      // Preload HI/LO via MTHI/MTLO.
      start = 1'b1;
      funct = F_MTHI;
      op_a  = 32'h0000_00AA;
      tick();
      funct = F_MTLO;
      op_a  = 32'h0000_00BB;
      tick();
      start = 1'b0;
      check("mthi_hi", hi, 32'h0000_00AA);
      check("mtlo_lo_bb", lo, 32'h0000_00BB);

      // DIV squashed at iteration 10.
      start = 1'b1;
      funct = F_DIV;
      op_a  = 32'd1000;
      op_b  = 32'd3;
      tick();
      check("flush_div_busy", 32'(busy), 32'd1);
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      start = 1'b0;
      #1;
      check("flush_busy",  32'(busy),  32'd0);
      check("flush_stall", 32'(stall), 32'd0);
      check("flush_hi", hi, 32'h0000_00AA);
      check("flush_lo", lo, 32'h0000_00BB);
      repeat (40) tick();
      check("flush_hi_later", hi, 32'h0000_00AA);
      check("flush_lo_later", lo, 32'h0000_00BB);

      // Async reset in the middle of a multiply.
      start = 1'b1;
      funct = F_MULT;
      op_a  = 32'd5;
      op_b  = 32'd9;
      tick();
      repeat (5) tick();
      check("mid_mul_busy", 32'(busy), 32'd1);
      #2;
      start = 1'b0;
      reset = 1'b0;
      #1;
      check("arst_hi",    hi,    32'h0);
      check("arst_lo",    lo,    32'h0);
      check("arst_busy",  32'(busy),  32'd0);
      check("arst_done",  32'(done),  32'd0);
      check("arst_stall", 32'(stall), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
